// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 decryption, one round per clock, with on-chip key expansion and key cache
module aes_decrypt_core #(
  parameter int NR = 10,
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_text,
  output logic         busy
);
  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt_core supports only NR=10");
  end
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] ISBOX = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d};
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;
  state_t state, nxt;
  logic [127:0] ct, st, t;
  logic [127:0] rk [0:10];
  logic [3:0] rnd;
  logic key_vld, hit;
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] b);
    return ISBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // multiply by 0x09/0x0b/0x0d/0x0e: all share the x8 term, low bits select x4, x2, x
  function automatic logic [7:0] mul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4;
    x2 = xt(x);
    x4 = xt(x2);
    return xt(x4) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
  endfunction
  function automatic logic [3:0] coef(input int k);
    return k == 0 ? 4'he : k == 1 ? 4'hb : k == 2 ? 4'hd : 4'h9;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ mul(s[127-8*(4*c+j) -: 8], coef((j - r + 4) % 4));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction
  function automatic logic [127:0] inv_ss(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = isb(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] tw, n0, n1, n2;
    tw = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rcon(r), 24'h0};
    n0 = k[127:96] ^ tw;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  assign hit = (KEY_CACHE != 0) && key_vld && (cipher_key == rk[0]);
  assign t = inv_ss(st) ^ rk[rnd];
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign plain_text = st;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? (hit ? INIT : KEYEXP) : IDLE;
      KEYEXP:  nxt = rnd == 4'd10 ? INIT : KEYEXP;
      INIT:    nxt = ROUND;
      ROUND:   nxt = rnd == 4'd0 ? DONE : ROUND;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // datapath: input capture, key expansion into the round-key store, inverse rounds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ct <= '0;
      st <= '0;
      rnd <= '0;
      key_vld <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          ct <= cipher_text;
          if (!hit) begin
            rk[0] <= cipher_key;
            rnd <= 4'd1;
          end
        end
        KEYEXP: begin
          rk[rnd] <= expand(rk[rnd - 4'd1], rnd);
          if (rnd == 4'd10) key_vld <= 1'b1;
          else rnd <= rnd + 4'd1;
        end
        INIT: begin
          st <= ct ^ rk[10];
          rnd <= 4'd9;
        end
        ROUND: begin
          st <= rnd != 4'd0 ? inv_mix(t) : t;
          if (rnd != 4'd0) rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
endmodule
